// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard-driven stall/bubble generation, with a run-mode
// FSM for the post-reset flush, sticky halt and debug freeze/step, plus event counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             dbg_freeze,
  input  logic             dbg_step_req,
  output logic             dbg_step_ack,
  input  logic             cnt_clr,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic             frozen,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_FREEZE,
    S_HALT
  } state_t;

  state_t state;
  logic   step_q;

  logic lu, mp, rt, exc_m, exc_w;
  logic step, normal;

  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == 3'd2) || (stat == 3'd3) || (stat == 3'd4);
  endfunction

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mp    = (E_icode == I_JXX) && !e_Cnd;
  assign rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign exc_m = is_exc(m_stat);
  assign exc_w = is_exc(W_stat);

  // A held step request is blocked on the cycle right after a step
  assign step         = (state == S_FREEZE) && dbg_step_req && !step_q;
  assign normal       = (state == S_RUN) || step;
  assign dbg_step_ack = step;
  assign halted       = (state == S_HALT);
  assign frozen       = (state == S_FREEZE);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (normal) begin
      F_stall  = lu | rt;
      D_stall  = lu;
      D_bubble = mp | (rt & !lu);
      E_bubble = mp | lu;
      M_bubble = exc_m | exc_w;
      W_stall  = exc_w;
    end else begin
      case (state)
        S_INIT: begin
          D_bubble = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
        end
        // E and M have no stall input; withholding their bubbles holds them
        S_FREEZE: begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          W_stall = 1'b1;
        end
        S_HALT: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          W_stall  = 1'b1;
          M_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      step_q    <= 1'b0;
      halt_stat <= 3'd0;
    end else begin
      step_q <= step;
      case (state)
        S_INIT: state <= S_RUN;
        S_RUN: begin
          if (exc_w) begin
            state     <= S_HALT;
            halt_stat <= W_stat;
          end else if (dbg_freeze) begin
            state <= S_FREEZE;
          end
        end
        S_FREEZE: begin
          if (step && exc_w) begin
            state     <= S_HALT;
            halt_stat <= W_stat;
          end else if (!dbg_freeze) begin
            state <= S_RUN;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      ret_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      ret_cnt <= '0;
    end else if (normal) begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (lu)       lu_cnt  <= lu_cnt + 1'b1;
      if (mp)       mp_cnt  <= mp_cnt + 1'b1;
      if (rt && !lu) ret_cnt <= ret_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. It drives the stall and bubble inputs of the F, D, E, M and W pipeline registers. Control signals come from hazard detection: load/use, `ret`, mispredicted `jXX`, and exceptional status. A small run-mode state machine adds three behaviours: a post-reset flush, a sticky halt on non-AOK writeback status, and a debug freeze/single-step handshake. Free-running event counters support performance debug.

## Interface
Parameters:
- `CNT_W`, 32: width of every event counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `D_icode`, `E_icode`, `M_icode`  in  4 each  icodes held in the D, E and M registers.
- `d_srcA`, `d_srcB`  in  4 each  decode-stage source register IDs (0xF = none).
- `E_dstM`  in  4  memory destination register held in the E register.
- `e_Cnd`  in  1  branch condition computed in execute.
- `m_stat`, `W_stat`  in  3 each  status codes: AOK=1, HLT=2, ADR=3, INS=4.
- `dbg_freeze`  in  1  level request to freeze the pipeline.
- `dbg_step_req`  in  1  request to advance one cycle while frozen.
- `dbg_step_ack`  out  1  one-cycle pulse marking the stepped cycle.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each  pipeline register controls.
- `halted`  out  1  sticky halt indication.
- `halt_stat`  out  3  W_stat value captured on halt entry.
- `frozen`  out  1  high while in FREEZE.
- `cyc_cnt`, `lu_cnt`, `mp_cnt`, `ret_cnt`  out  CNT_W each  counters: running cycles, load/use stalls, mispredicts, ret-bubble cycles.

## Operation
Hazard terms (combinational):
- `lu` = `E_icode` ∈ {MRMOVQ=5, POPQ=0xB} and `E_dstM` ≠ 0xF and `E_dstM` ∈ {`d_srcA`, `d_srcB`}.
- `mp` = `E_icode` == JXX=7 and !`e_Cnd`.
- `rt` = RET=9 ∈ {`D_icode`, `E_icode`, `M_icode`}.
- `exc_m` = `m_stat` ∈ {2,3,4}.
- `exc_w` = `W_stat` ∈ {2,3,4}.

Normal control, applied in RUN and on a step cycle:
- `F_stall` = `lu` | `rt`.
- `D_stall` = `lu`.
- `D_bubble` = `mp` | (`rt` & !`lu`).
- `E_bubble` = `mp` | `lu`.
- `M_bubble` = `exc_m` | `exc_w`.
- `W_stall` = `exc_w`.
- Stall and bubble are never both high on the same register.

States (reset state is INIT):
- INIT: `D_bubble`, `E_bubble` and `M_bubble` are 1; all stalls are 0. Always moves to RUN after one cycle.
- RUN: normal control.
  - `exc_w` → HALT, capturing `halt_stat` = `W_stat`. Priority over `dbg_freeze`.
  - Otherwise `dbg_freeze` → FREEZE.
- FREEZE: all five stalls are 1 (`F_stall`, `D_stall`, `W_stall`, plus E and M held by forcing both bubbles to 0, since the E and M registers have no stall input). Counters do not advance.
  - `dbg_step_req` high: that cycle uses normal control, `dbg_step_ack` pulses, and the state remains FREEZE. A held request yields at most one step every two cycles; the cycle after an ack ignores the request.
  - `exc_w` during a step cycle → HALT.
  - `dbg_freeze` low → RUN.
- HALT: `F_stall`, `D_stall` and `W_stall` are 1; `M_bubble` is 1; `halted` is 1. Exit only via reset. Debug inputs are ignored.

Counters:
- Wrap modulo 2^CNT_W.
- Increment only on cycles using normal control (RUN or step): `cyc_cnt` always; `lu_cnt` on `lu`; `mp_cnt` on `mp`; `ret_cnt` on `rt` & !`lu`.
- `cnt_clr` has priority over increment.

## Timing
- Reset values: state INIT, `halted`=0, `halt_stat`=0, `frozen`=0, `dbg_step_ack`=0, all counters 0. Stall/bubble outputs show INIT values (bubbles D/E/M = 1) while `rst_n` is low.
- Stall/bubble outputs are combinational from state and inputs, valid before the next rising edge. `halted`, `frozen`, `halt_stat` and counters are registered, with 1-cycle latency.
- Reset asserted mid-operation, including in HALT or FREEZE, returns to INIT immediately.
- Simultaneous `lu` and `rt`: F and D stall, E bubbles, D does not bubble.
- Simultaneous `mp` and `rt`: F stalls, D and E bubble.

## Test plan
- Reset release → one INIT cycle with D/E/M bubbles = 1, then RUN with all controls 0 for `E_icode`=1 (NOP).
- Load/use: `E_icode`=5, `E_dstM`=3, `d_srcA`=3 → `F_stall`=`D_stall`=`E_bubble`=1, `D_bubble`=0, `lu_cnt` 0→1. Repeat with `E_dstM`=0xF → no stall.
- Mispredict: `E_icode`=7, `e_Cnd`=0, `D_icode`=9 → `F_stall`=1, `D_bubble`=`E_bubble`=1, `mp_cnt`=1, `ret_cnt`=1.
- Halt: `W_stat`=3 in RUN → `W_stall`=`M_bubble`=1. Next cycle `halted`=1, `halt_stat`=3. Asserting `dbg_freeze` has no effect; only `rst_n` clears.
- Debug: `dbg_freeze`=1 → `frozen`=1, all stalls 1, `cyc_cnt` constant for 5 cycles. Held `dbg_step_req` for 4 cycles → exactly 2 ack pulses, `cyc_cnt` +2. Releasing `dbg_freeze` → RUN.
- Counter wrap and clear with `CNT_W`=4: 16 RUN cycles → `cyc_cnt` wraps to 0. `cnt_clr` together with `lu` → `lu_cnt`=0.
